// File: rtl/moore_fsm.sv
// moore_fsm
//   Two-state Moore machine that follows a single-bit input level. The output
//   is decoded from the state register only, so an input change sampled at a
//   rising edge shows up on the output just after that edge, and the output
//   cannot move between edges however the input behaves.
//
// Ports
//   clk    in   1  system clock, all state updates on the rising edge
//   reset  in   1  synchronous active-high reset, forces STATE_A
//   in     in   1  control input, sampled on the rising edge
//   out    out  1  Moore output, OUT_IN_A in STATE_A, OUT_IN_B in STATE_B
`timescale 1ns/1ps

module moore_fsm #(
  parameter logic OUT_IN_A = 1'b0,
  parameter logic OUT_IN_B = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  typedef enum logic {
    STATE_A = 1'b0,
    STATE_B = 1'b1
  } state_e;

  state_e state_q;
  state_e state_d;

  // Next-state logic. The default branch also catches an unknown state
  // and steers it back to STATE_A.
  always_comb begin
    state_d = STATE_A;
    case (state_q)
      STATE_A: state_d = in ? STATE_B : STATE_A;
      STATE_B: state_d = in ? STATE_B : STATE_A;
      default: state_d = STATE_A;
    endcase
  end

  // State register; reset wins over any transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= STATE_A;
    end else begin
      state_q <= state_d;
    end
  end

  // Output decode looks only at the state register, never at in.
  always_comb begin
    out = OUT_IN_A;
    case (state_q)
      STATE_A: out = OUT_IN_A;
      STATE_B: out = OUT_IN_B;
      default: out = OUT_IN_A;
    endcase
  end

endmodule

// File: tb/tb_moore_fsm.sv
// tb_moore_fsm
//   Directed bench for moore_fsm. Inputs change on a fixed absolute timeline
//   (clock period 10 ns, rising edges at 5, 15, 25, ...) and the output is
//   sampled 1 ns after an edge or in the middle of a cycle.
`timescale 1ns/1ps

module tb_moore_fsm;

  logic clk;
  logic reset;
  logic in;
  logic out;

  int checkCount;
  int errorCount;

  moore_fsm #(
    .OUT_IN_A(1'b0),
    .OUT_IN_B(1'b1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .in   (in),
    .out  (out)
  );

  // Free-running clock with rising edges at 5, 15, 25, ... ns.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive both inputs together.
  task automatic applyStimulus(input logic resetVal, input logic inVal);
    reset = resetVal;
    in    = inVal;
  endtask

  // Single comparison point: counts every check, reports any mismatch.
  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: out=%b expected=%b at %0t", tag, observed, expected, $time);
    end
  endtask

  // Directed timeline; comments give the absolute time reached.
  initial begin
    logic [7:0] togglePattern;
    logic       prevOut;

    checkCount    = 0;
    errorCount    = 0;
    togglePattern = 8'b1011_0101;

    // Reset with in low.
    applyStimulus(1'b1, 1'b0);
    #6;  // 6
    checkOutput("reset", out, 1'b0);
    #4;  // 10
    applyStimulus(1'b0, 1'b0);
    #16; // 26
    checkOutput("idle_a", out, 1'b0);

    // A -> B, with no combinational path from in.
    #4;  // 30
    applyStimulus(1'b0, 1'b1);
    #4;  // 34
    checkOutput("no_comb_path", out, 1'b0);
    #2;  // 36
    checkOutput("a_to_b", out, 1'b1);

    // B -> A and hold.
    #4;  // 40
    applyStimulus(1'b0, 1'b0);
    #6;  // 46
    checkOutput("b_to_a", out, 1'b0);
    #10; // 56
    checkOutput("hold_a", out, 1'b0);

    // Re-entry into B and hold.
    #4;  // 60
    applyStimulus(1'b0, 1'b1);
    #6;  // 66
    checkOutput("reentry_b", out, 1'b1);
    #10; // 76
    checkOutput("hold_b", out, 1'b1);

    // Reset priority from STATE_B with in still high.
    #4;  // 80
    applyStimulus(1'b1, 1'b1);
    #6;  // 86
    checkOutput("reset_priority", out, 1'b0);
    #10; // 96
    checkOutput("reset_held", out, 1'b0);

    // Release reset with in high: B again one edge later.
    #4;  // 100
    applyStimulus(1'b0, 1'b1);
    #6;  // 106
    checkOutput("post_reset_b", out, 1'b1);

    // Return to A, then a 3 ns in pulse entirely between edges.
    #4;  // 110
    applyStimulus(1'b0, 1'b0);
    #6;  // 116
    checkOutput("pre_glitch_a", out, 1'b0);
    #1;  // 117
    applyStimulus(1'b0, 1'b1);
    #1;  // 118
    checkOutput("glitch_during", out, 1'b0);
    #2;  // 120
    applyStimulus(1'b0, 1'b0);
    #6;  // 126
    checkOutput("glitch_after", out, 1'b0);

    // Toggle in every cycle: out follows one edge later and never mid-cycle.
    prevOut = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #4;  // 130 + 10*i
      applyStimulus(1'b0, togglePattern[i]);
      #4;  // 134 + 10*i
      checkOutput($sformatf("toggle_pre_%0d", i), out, prevOut);
      #2;  // 136 + 10*i
      checkOutput($sformatf("toggle_post_%0d", i), out, togglePattern[i]);
      prevOut = togglePattern[i];
    end

    // Final reset from whichever state the pattern left.
    #4;
    applyStimulus(1'b1, 1'b0);
    #6;
    checkOutput("final_reset", out, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
